// File: rtl/inert_intf_mch_if.sv
// SPI transaction handshake between inert_intf_mch (master) and the external SPI engine (slave).
interface inert_intf_mch_if;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;

  modport master (output wrt, cmd, input done, rd_data);
  modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/inert_intf_mch.sv
// Multi-channel inertial sensor front end: power-up wait, SPI init sequence, INT-driven frame reads.
// Optional clamp filter on published words is enabled by defining INERT_CLAMP_EN.
module inert_intf_mch #(
  parameter int           NUM_CH    = 2,
  parameter logic [31:0]  CH_ADDR   = 32'h0000_2C22,
  parameter int           NUM_INIT  = 4,
  parameter logic [127:0] INIT_CMDS = 128'h0000_0000_0000_0000_1460_1150_1053_0D02,
  parameter int           PWR_CYC   = 65536,
  parameter int           GAP_CYC   = 1024,
  parameter int           TMO_CYC   = 65535,
  parameter logic [15:0]  CLAMP     = 16'h1F00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   INT,
  inert_intf_mch_if.master       spi,
  output logic [16*NUM_CH-1:0]   data,
  output logic                   vld,
  output logic                   init_done,
  output logic                   timeout,
  output logic                   ovr
);

  localparam int PW = $clog2(PWR_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [PW-1:0] PWR_LAST = PW'(PWR_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TMO_CYC);
  localparam logic [3:0]    N_INIT   = 4'(NUM_INIT);
  localparam logic [1:0]    LAST_CH  = 2'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_INIT_W, S_IDLE, S_RD, S_RD_W, S_PUB
  } state_t;

  state_t                   state_q, state_d;
  logic [PW-1:0]            pwr_q, pwr_d;
  logic [GW-1:0]            gap_q, gap_d;
  logic [TW-1:0]            tmo_q, tmo_d;
  logic [3:0]               k_q, k_d;
  logic [1:0]               ch_q, ch_d;
  logic                     hi_q, hi_d;
  logic                     pending_q, pending_d;
  logic [2:0]               sync_q, sync_d;
  logic [NUM_CH-1:0][15:0]  shadow_q, shadow_d;
  logic [NUM_CH-1:0][15:0]  data_q, data_d;
  logic                     vld_q, vld_d;
  logic                     init_done_q, init_done_d;
  logic                     timeout_q, timeout_d;
  logic                     ovr_q, ovr_d;

  logic                     rise;
  logic                     wrt_c;
  logic [15:0]              cmd_c;
  logic [6:0]               base_addr;
  logic [6:0]               rd_addr;
  logic [7:0]               unused_rd_hi;

  assign unused_rd_hi = spi.rd_data[15:8];

`ifdef INERT_CLAMP_EN
  function automatic logic [15:0] clamp_w(input logic [15:0] w);
    if ($signed(w) > $signed(CLAMP) || $signed(w) < -$signed(CLAMP))
      return '0;
    return w;
  endfunction
`else
  logic [15:0] unused_clamp;
  assign unused_clamp = CLAMP;
`endif

  // sync_q[1] is the second synchroniser stage; sync_q[2] holds its previous value for edge detect
  assign rise      = sync_q[1] & ~sync_q[2];
  assign base_addr = CH_ADDR[{ch_q, 3'b000} +: 7];
  assign rd_addr   = base_addr + {6'd0, hi_q};

  always_comb begin
    state_d     = state_q;
    pwr_d       = pwr_q;
    gap_d       = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    tmo_d       = tmo_q;
    k_d         = k_q;
    ch_d        = ch_q;
    hi_d        = hi_q;
    pending_d   = pending_q | rise;
    sync_d      = {sync_q[1:0], INT};
    shadow_d    = shadow_q;
    data_d      = data_q;
    vld_d       = 1'b0;
    init_done_d = init_done_q;
    timeout_d   = timeout_q;
    ovr_d       = rise & pending_q & (state_q != S_IDLE);
    wrt_c       = 1'b0;
    cmd_c       = INIT_CMDS[{k_q[2:0], 4'b0000} +: 16];

    case (state_q)
      S_PWRUP: begin
        pwr_d = pwr_q + PW'(1);
        if (pwr_q == PWR_LAST) begin
          state_d = S_INIT;
          k_d     = '0;
          gap_d   = '0;
        end
      end
      S_INIT: begin
        if (gap_q == '0) begin
          wrt_c   = 1'b1;
          state_d = S_INIT_W;
        end
      end
      S_INIT_W: begin
        if (spi.done) begin
          k_d   = k_q + 4'd1;
          gap_d = GAP_LOAD;
          if (k_q + 4'd1 == N_INIT) begin
            init_done_d = 1'b1;
            tmo_d       = '0;
            state_d     = S_IDLE;
          end else begin
            state_d = S_INIT;
          end
        end
      end
      S_IDLE: begin
        if (tmo_q != TMO_MAX)
          tmo_d = tmo_q + TW'(1);
        if (tmo_d == TMO_MAX && init_done_q)
          timeout_d = 1'b1;
        // a rise in the same cycle as the take keeps pending armed
        if (pending_q) begin
          pending_d = rise;
          tmo_d     = '0;
          ch_d      = '0;
          hi_d      = 1'b0;
          gap_d     = GAP_LOAD;
          state_d   = S_RD;
        end
      end
      S_RD: begin
        cmd_c = {1'b1, rd_addr, 8'h00};
        if (gap_q == '0) begin
          wrt_c   = 1'b1;
          state_d = S_RD_W;
        end
      end
      S_RD_W: begin
        cmd_c = {1'b1, rd_addr, 8'h00};
        if (spi.done) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ch_q == 2'(i)) begin
              if (hi_q) shadow_d[i][15:8] = spi.rd_data[7:0];
              else      shadow_d[i][7:0]  = spi.rd_data[7:0];
            end
          end
          gap_d = GAP_LOAD;
          if (!hi_q) begin
            hi_d    = 1'b1;
            state_d = S_RD;
          end else if (ch_q == LAST_CH) begin
            state_d = S_PUB;
          end else begin
            ch_d    = ch_q + 2'd1;
            hi_d    = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_PUB: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef INERT_CLAMP_EN
          data_d[i] = clamp_w(shadow_q[i]);
`else
          data_d[i] = shadow_q[i];
`endif
        end
        vld_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PWRUP;
      pwr_q       <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      k_q         <= '0;
      ch_q        <= '0;
      hi_q        <= 1'b0;
      pending_q   <= 1'b0;
      sync_q      <= '0;
      shadow_q    <= '0;
      data_q      <= '0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pwr_q       <= pwr_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      k_q         <= k_d;
      ch_q        <= ch_d;
      hi_q        <= hi_d;
      pending_q   <= pending_d;
      sync_q      <= sync_d;
      shadow_q    <= shadow_d;
      data_q      <= data_d;
      vld_q       <= vld_d;
      init_done_q <= init_done_d;
      timeout_q   <= timeout_d;
      ovr_q       <= ovr_d;
    end
  end

  assign spi.wrt   = wrt_c;
  assign spi.cmd   = cmd_c;
  assign data      = data_q;
  assign vld       = vld_q;
  assign init_done = init_done_q;
  assign timeout   = timeout_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_inert_intf_mch.sv
// Directed scoreboard bench for inert_intf_mch: init sequence, frame reads, clamp, overrun, timeout, mid-frame reset.
module tb_inert_intf_mch;
  localparam int NUM_CH   = 2;
  localparam int PWR      = 16;
  localparam int GAP      = 4;
  localparam int TMO      = 100;
  localparam int DONE_LAT = 8;

  typedef struct {
    logic [15:0] cmd;
    int          gchk;  // 0: no gap check, 1: exact GAP after done, 2: bounded frame restart
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        INT;
  logic [31:0] data;
  logic        vld, init_done, timeout, ovr;

  inert_intf_mch_if spi_if ();

  inert_intf_mch #(
    .NUM_CH  (NUM_CH),
    .PWR_CYC (PWR),
    .GAP_CYC (GAP),
    .TMO_CYC (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .spi       (spi_if),
    .data      (data),
    .vld       (vld),
    .init_done (init_done),
    .timeout   (timeout),
    .ovr       (ovr)
  );

  always #5 clk = ~clk;

  cmd_t        exp_cmd_q[$];
  logic [7:0]  rsp_q[$];
  logic [31:0] exp_data_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  int n_wrt = 0, n_done = 0, n_vld = 0, n_ovr = 0;
  int cnt = 0;
  int last_done_cyc = -1000;
  int rel_cyc = 0, first_wrt_cyc = -1, done_base = 0;
  bit arm_first = 1'b0;
  bit id_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pub(input logic [15:0] w);
`ifdef INERT_CLAMP_EN
    if ($signed(w) > $signed(16'h1F00) || $signed(w) < -$signed(16'h1F00))
      return 16'h0000;
`endif
    return w;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // SPI slave model plus output monitors, all sampled on the falling edge
  initial begin
    cmd_t e;
    logic [31:0] ed;
    spi_if.done    = 1'b0;
    spi_if.rd_data = '0;
    forever begin
      @(negedge clk);
      spi_if.done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_if.done    = 1'b1;
          spi_if.rd_data = {8'hA5, (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00};
          n_done++;
          last_done_cyc = cyc;
        end
      end
      if (spi_if.wrt === 1'b1) begin
        n_wrt++;
        check("wrt_while_busy", (cnt > 0), 0);
        if (arm_first) begin
          first_wrt_cyc = cyc;
          arm_first     = 1'b0;
        end
        check("wrt_expected", (exp_cmd_q.size() > 0), 1);
        if (exp_cmd_q.size() > 0) begin
          e = exp_cmd_q.pop_front();
          check("cmd", spi_if.cmd, e.cmd);
          if (e.gchk == 1) check("gap", cyc - last_done_cyc, GAP);
          if (e.gchk == 2) check("frame_restart_gap", (cyc - last_done_cyc) <= GAP + 2, 1);
        end
        cnt = DONE_LAT;
      end
      if (vld === 1'b1) begin
        n_vld++;
        check("vld_expected", (exp_data_q.size() > 0), 1);
        if (exp_data_q.size() > 0) begin
          ed = exp_data_q.pop_front();
          check("data", data, ed);
        end
      end
      if (ovr === 1'b1) n_ovr++;
      if (init_done === 1'b1 && !id_prev) check("init_done_on_4th_done", n_done - done_base, 4);
      id_prev = (init_done === 1'b1);
    end
  end

  task automatic release_rst();
    cmd_t c;
    logic [15:0] init_cmds [4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    for (int i = 0; i < 4; i++) begin
      c.cmd  = init_cmds[i];
      c.gchk = (i == 0) ? 0 : 1;
      exp_cmd_q.push_back(c);
      rsp_q.push_back(8'h00);
    end
    rst       = 1'b0;
    rel_cyc   = cyc;
    done_base = n_done;
    arm_first = 1'b1;
  endtask

  task automatic wait_init();
    int t = 0;
    while (init_done !== 1'b1 && t < 400) begin
      tick(1);
      t++;
    end
    check("init_done_reached", init_done, 1);
    check("first_wrt_cycle", first_wrt_cyc - rel_cyc, PWR);
    check("init_cmds_consumed", exp_cmd_q.size(), 0);
  endtask

  task automatic push_frame(input logic [7:0] lo0, input logic [7:0] hi0,
                            input logic [7:0] lo1, input logic [7:0] hi1, input int g0);
    cmd_t c;
    logic [15:0] cmds [4] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    for (int i = 0; i < 4; i++) begin
      c.cmd  = cmds[i];
      c.gchk = (i == 0) ? g0 : 1;
      exp_cmd_q.push_back(c);
    end
    rsp_q.push_back(lo0);
    rsp_q.push_back(hi0);
    rsp_q.push_back(lo1);
    rsp_q.push_back(hi1);
    exp_data_q.push_back({pub({hi1, lo1}), pub({hi0, lo0})});
  endtask

  task automatic int_pulse();
    INT = 1'b1;
    tick(3);
    INT = 1'b0;
    tick(3);
  endtask

  task automatic wait_vld(input int target);
    int t = 0;
    while (n_vld < target && t < 300) begin
      tick(1);
      t++;
    end
    check("vld_seen", (n_vld >= target), 1);
  endtask

  task automatic wait_wrt(input int target);
    int t = 0;
    while (n_wrt < target && t < 300) begin
      tick(1);
      t++;
    end
    check("wrt_seen", (n_wrt >= target), 1);
  endtask

  initial begin
    int v0, w0, o0, t;
    rst = 1'b1;
    INT = 1'b0;
    @(posedge clk);
    tick(1);
    check("rst_data", data, 32'h0);
    check("rst_vld", vld, 0);
    check("rst_init_done", init_done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ovr", ovr, 0);
    check("rst_wrt", spi_if.wrt, 0);

    release_rst();
    wait_init();

    tick(95);
    check("timeout_early", timeout, 0);
    tick(10);
    check("timeout_set", timeout, 1);

    v0 = n_vld;
    push_frame(8'h34, 8'h12, 8'h00, 8'hC0, 0);
    int_pulse();
    wait_vld(v0 + 1);
    check("timeout_sticky", timeout, 1);

    tick(5);
    push_frame(8'h00, 8'h20, 8'h00, 8'hE1, 0);
    int_pulse();
    wait_vld(v0 + 2);
    tick(5);
    push_frame(8'h00, 8'h1F, 8'hFF, 8'hE0, 0);
    int_pulse();
    wait_vld(v0 + 3);
    check("ovr_quiet", n_ovr, 0);

    tick(5);
    v0 = n_vld;
    w0 = n_wrt;
    o0 = n_ovr;
    push_frame(8'h11, 8'h22, 8'h33, 8'h44, 0);
    push_frame(8'h55, 8'h66, 8'h77, 8'h08, 2);
    int_pulse();
    wait_wrt(w0 + 2);
    int_pulse();
    int_pulse();
    wait_vld(v0 + 2);
    tick(60);
    check("overrun_frames", n_vld - v0, 2);
    check("ovr_pulses", n_ovr - o0, 1);
    check("overrun_cmds_consumed", exp_cmd_q.size(), 0);

    v0 = n_vld;
    push_frame(8'h01, 8'h02, 8'h03, 8'h04, 0);
    int_pulse();
    wait_vld(v0 + 1);
    tick(5);
    w0 = n_wrt;
    push_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD, 0);
    int_pulse();
    wait_wrt(w0 + 3);
    t = 0;
    while (cnt != 1 && t < 50) begin
      tick(1);
      t++;
    end
    check("reset_window_found", cnt, 1);
    rst = 1'b1;
    tick(1);
    check("midrst_data", data, 32'h0);
    check("midrst_vld", vld, 0);
    check("midrst_init_done", init_done, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_ovr", ovr, 0);
    check("midrst_wrt", spi_if.wrt, 0);
    exp_cmd_q.delete();
    exp_data_q.delete();
    rsp_q.delete();
    release_rst();
    tick(2);
    check("stray_done_no_publish", data, 32'h0);
    wait_init();

    v0 = n_vld;
    push_frame(8'h78, 8'h06, 8'h9A, 8'hFB, 0);
    int_pulse();
    wait_vld(v0 + 1);
    tick(20);
    check("final_cmd_queue", exp_cmd_q.size(), 0);
    check("final_data_queue", exp_data_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
